// File: rtl/card_session_ctrl_if.sv
// Card session bus: user-side strobes, account provisioning port and session status outputs.
// The master side drives the user/provisioning inputs; the slave side is the session controller.
interface card_session_ctrl_if #(
  parameter int CARD_WIDTH     = 6,
  parameter int PASSWORD_WIDTH = 16,
  parameter int BALANCE_WIDTH  = 20,
  parameter int USERS_NUM      = 10,
  parameter int MAX_TRIES      = 3
);
  localparam int IDX_W   = (USERS_NUM > 1) ? $clog2(USERS_NUM) : 1;
  localparam int TRIES_W = $clog2(MAX_TRIES + 1);

  logic                      card_in;
  logic [CARD_WIDTH-1:0]     card_number;
  logic                      psw_valid;
  logic [PASSWORD_WIDTH-1:0] password_input;
  logic                      op_done;
  logic [BALANCE_WIDTH-1:0]  updated_balance;
  logic                      card_out;

  logic                      db_we;
  logic [IDX_W-1:0]          db_idx;
  logic [CARD_WIDTH-1:0]     db_card;
  logic [PASSWORD_WIDTH-1:0] db_psw;
  logic [BALANCE_WIDTH-1:0]  db_bal;

  logic [BALANCE_WIDTH-1:0]  balance;
  logic                      psw_en;
  logic                      wrong_psw;
  logic                      authenticated;
  logic                      invalid_card;
  logic                      card_locked;
  logic                      eject;
  logic [TRIES_W-1:0]        tries_left;

  modport master (
    output card_in, card_number, psw_valid, password_input, op_done, updated_balance, card_out,
    output db_we, db_idx, db_card, db_psw, db_bal,
    input  balance, psw_en, wrong_psw, authenticated, invalid_card, card_locked, eject, tries_left
  );

  modport slave (
    input  card_in, card_number, psw_valid, password_input, op_done, updated_balance, card_out,
    input  db_we, db_idx, db_card, db_psw, db_bal,
    output balance, psw_en, wrong_psw, authenticated, invalid_card, card_locked, eject, tries_left
  );
endinterface

// File: rtl/card_session_ctrl.sv
// Card session controller: account table, card lookup, password check with lockout,
// balance commit and inactivity eject. All outputs come from registers.
module card_session_ctrl #(
  parameter int CARD_WIDTH     = 6,
  parameter int PASSWORD_WIDTH = 16,
  parameter int BALANCE_WIDTH  = 20,
  parameter int USERS_NUM      = 10,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  card_session_ctrl_if.slave bus
);
  localparam int IDX_W   = (USERS_NUM > 1) ? $clog2(USERS_NUM) : 1;
  localparam int TRIES_W = $clog2(MAX_TRIES + 1);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TRIES_W-1:0] MAX_TRIES_V = TRIES_W'(MAX_TRIES);
  localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, WAIT_PSW, AUTH} state_e;

  state_e state_q, state_d;

  logic                      valid_q    [USERS_NUM];
  logic                      locked_q   [USERS_NUM];
  logic [CARD_WIDTH-1:0]     card_tbl_q [USERS_NUM];
  logic [PASSWORD_WIDTH-1:0] psw_tbl_q  [USERS_NUM];
  logic [BALANCE_WIDTH-1:0]  bal_tbl_q  [USERS_NUM];

  logic                      card_in_q;
  logic [CARD_WIDTH-1:0]     card_q, card_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [TRIES_W-1:0]        tries_q, tries_d;
  logic [TIMER_W-1:0]        timer_q, timer_d;
  logic [BALANCE_WIDTH-1:0]  balance_q, balance_d;
  logic                      wrong_q, wrong_d;
  logic                      invalid_q, invalid_d;
  logic                      locked_pulse_q, locked_pulse_d;
  logic                      eject_q, eject_d;

  logic                      card_rise;
  logic                      db_wr, lock_set, bal_wr;
  logic                      hit, hit_locked;
  logic [IDX_W-1:0]          hit_idx;
  logic [PASSWORD_WIDTH-1:0] sel_psw;
  logic [BALANCE_WIDTH-1:0]  sel_bal;

  assign card_rise = bus.card_in & ~card_in_q;

  // Lowest valid matching index wins.
  always_comb begin
    hit        = 1'b0;
    hit_locked = 1'b0;
    hit_idx    = '0;
    for (int unsigned i = 0; i < USERS_NUM; i++) begin
      if (!hit && valid_q[i] && (card_tbl_q[i] == card_q)) begin
        hit        = 1'b1;
        hit_locked = locked_q[i];
        hit_idx    = IDX_W'(i);
      end
    end
  end

  always_comb begin
    sel_psw = '0;
    sel_bal = '0;
    for (int unsigned i = 0; i < USERS_NUM; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_psw = psw_tbl_q[i];
        sel_bal = bal_tbl_q[i];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    card_d         = card_q;
    idx_d          = idx_q;
    tries_d        = tries_q;
    timer_d        = timer_q;
    balance_d      = '0;
    wrong_d        = 1'b0;
    invalid_d      = 1'b0;
    locked_pulse_d = 1'b0;
    eject_d        = 1'b0;
    db_wr          = 1'b0;
    lock_set       = 1'b0;
    bal_wr         = 1'b0;

    case (state_q)
      IDLE: begin
        tries_d = '0;
        timer_d = '0;
        db_wr   = bus.db_we && (32'(bus.db_idx) < 32'(USERS_NUM));
        if (card_rise) begin
          card_d  = bus.card_number;
          state_d = LOOKUP;
        end
      end

      LOOKUP: begin
        if (!hit) begin
          invalid_d = 1'b1;
          eject_d   = 1'b1;
          state_d   = IDLE;
        end else if (hit_locked) begin
          locked_pulse_d = 1'b1;
          eject_d        = 1'b1;
          state_d        = IDLE;
        end else begin
          idx_d   = hit_idx;
          tries_d = '0;
          timer_d = '0;
          state_d = WAIT_PSW;
        end
      end

      WAIT_PSW: begin
        if (bus.card_out) begin
          eject_d = 1'b1;
          state_d = IDLE;
        end else if (bus.psw_valid) begin
          timer_d = '0;
          if (bus.password_input == sel_psw) begin
            balance_d = sel_bal;
            state_d   = AUTH;
          end else begin
            wrong_d = 1'b1;
            if (tries_q + 1'b1 == MAX_TRIES_V) begin
              lock_set       = 1'b1;
              locked_pulse_d = 1'b1;
              eject_d        = 1'b1;
              state_d        = IDLE;
            end else begin
              tries_d = tries_q + 1'b1;
            end
          end
        end else if (bus.op_done) begin
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          eject_d = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      AUTH: begin
        // A commit lands in the table even when the card is ejected in the same cycle.
        bal_wr = bus.op_done;
        if (bus.card_out) begin
          eject_d = 1'b1;
          state_d = IDLE;
        end else if (bus.op_done || bus.psw_valid) begin
          timer_d   = '0;
          balance_d = bus.op_done ? bus.updated_balance : sel_bal;
        end else if (timer_q == TIMER_LAST) begin
          eject_d = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d   = timer_q + 1'b1;
          balance_d = sel_bal;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      card_in_q      <= 1'b0;
      card_q         <= '0;
      idx_q          <= '0;
      tries_q        <= '0;
      timer_q        <= '0;
      balance_q      <= '0;
      wrong_q        <= 1'b0;
      invalid_q      <= 1'b0;
      locked_pulse_q <= 1'b0;
      eject_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      card_in_q      <= bus.card_in;
      card_q         <= card_d;
      idx_q          <= idx_d;
      tries_q        <= tries_d;
      timer_q        <= timer_d;
      balance_q      <= balance_d;
      wrong_q        <= wrong_d;
      invalid_q      <= invalid_d;
      locked_pulse_q <= locked_pulse_d;
      eject_q        <= eject_d;
    end
  end

  // Provisioning (IDLE only) and session updates (never IDLE) cannot collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < USERS_NUM; i++) begin
        valid_q[i]    <= 1'b0;
        locked_q[i]   <= 1'b0;
        card_tbl_q[i] <= '0;
        psw_tbl_q[i]  <= '0;
        bal_tbl_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < USERS_NUM; i++) begin
        if (db_wr && (bus.db_idx == IDX_W'(i))) begin
          valid_q[i]    <= 1'b1;
          locked_q[i]   <= 1'b0;
          card_tbl_q[i] <= bus.db_card;
          psw_tbl_q[i]  <= bus.db_psw;
          bal_tbl_q[i]  <= bus.db_bal;
        end else if (idx_q == IDX_W'(i)) begin
          if (lock_set) locked_q[i]  <= 1'b1;
          if (bal_wr)   bal_tbl_q[i] <= bus.updated_balance;
        end
      end
    end
  end

  assign bus.balance       = balance_q;
  assign bus.psw_en        = (state_q == WAIT_PSW);
  assign bus.authenticated = (state_q == AUTH);
  assign bus.wrong_psw     = wrong_q;
  assign bus.invalid_card  = invalid_q;
  assign bus.card_locked   = locked_pulse_q;
  assign bus.eject         = eject_q;
  assign bus.tries_left    = (state_q == WAIT_PSW) ? (MAX_TRIES_V - tries_q) : MAX_TRIES_V;
endmodule
